adaptador_fijo_bcd: RTL and testbench

Parametrised fixed-point to BCD converter for the velocimetro display path. It accepts an unsigned or two's-complement fixed-point speed sample with a valid/ready handshake and splits it into integer and fraction fields. It converts the integer field to packed BCD using iterative double-dabble and the fraction field to decimal digits by repeated multiply-by-10. It saturates on overflow and presents registered results to the display driver until they are consumed.

---
 rtl/adaptador_fijo_bcd.sv | 150 +++++++++++++++
 tb/tb_adaptador_fijo_bcd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adaptador_fijo_bcd.sv
// Fixed-point speed sample to packed BCD for the velocimetro display: double-dabble
// on the integer field, repeated multiply-by-10 on the fraction field.
module adaptador_fijo_bcd #(
   parameter int IN_W        = 24,
   parameter int INT_W       = 16,
   parameter int FRAC_W      = 4,
   parameter int INT_DIGITS  = 5,
   parameter int FRAC_DIGITS = 2,
   parameter bit SIGNED      = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IN_W-1:0]          fixedPoint,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [INT_W-1:0]         entero,
   output logic [FRAC_W-1:0]        decimal,
   output logic [4*INT_DIGITS-1:0]  entero_bcd,
   output logic [4*FRAC_DIGITS-1:0] decimal_bcd,
   output logic                     negativo,
   output logic                     overflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               estado_dbg
);

   // Handshake: a sample transfers on in_valid && in_ready (only in IDLE); a result
   // transfers on out_valid && out_ready (only in DONE), with outputs held until then.
   typedef enum logic [1:0] {IDLE, INT_CONV, FRAC_CONV, DONE} estado_t;

   localparam int CNT_W = $clog2(INT_W + FRAC_DIGITS + 1);
   localparam int BCD_W = 4*INT_DIGITS;
   localparam int FB_W  = 4*FRAC_DIGITS;
   localparam logic [FRAC_W+3:0] DIEZ = (FRAC_W+4)'(10);

   estado_t           estado, estado_sig;
   logic [CNT_W-1:0]  cnt;
   logic [IN_W:0]     ext, mag;
   logic              neg_in, fuera;
   logic [INT_W-1:0]  ent_in, ent_w, bin_sr;
   logic [FRAC_W-1:0] dec_in, dec_w, frac_w;
   logic [BCD_W-1:0]  bcd_sr, bcd_adj;
   logic [FB_W-1:0]   fb_sr, fb_next;
   logic [FRAC_W+3:0] t;
   logic              neg_w, ovf_w;
   logic              ult_int, ult_frac;

   assign estado_dbg = estado;

   // Magnitude is formed one bit wider so negating the most negative input cannot wrap.
   always_comb begin
      neg_in = SIGNED & fixedPoint[IN_W-1];
      ext    = {(SIGNED ? fixedPoint[IN_W-1] : 1'b0), fixedPoint};
      mag    = neg_in ? (IN_W+1)'(-ext) : ext;
      fuera  = |mag[IN_W:INT_W+FRAC_W];
      ent_in = fuera ? '1 : mag[INT_W+FRAC_W-1:FRAC_W];
      dec_in = fuera ? '1 : mag[FRAC_W-1:0];
   end

   always_comb begin
      bcd_adj = bcd_sr;
      for (int i = 0; i < INT_DIGITS; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
      t           = {4'b0000, frac_w} * DIEZ;
      fb_next     = fb_sr << 4;
      fb_next[3:0] = t[FRAC_W+3:FRAC_W];
   end

   assign ult_int  = (cnt == CNT_W'(INT_W-1));
   assign ult_frac = (cnt == CNT_W'(FRAC_DIGITS-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= IDLE;
      else       estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (estado)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) estado_sig = INT_CONV;
         end
         INT_CONV:  if (ult_int)  estado_sig = FRAC_CONV;
         FRAC_CONV: if (ult_frac) estado_sig = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) estado_sig = IDLE;
         end
         default: estado_sig = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         neg_w       <= 1'b0;
         ovf_w       <= 1'b0;
         ent_w       <= '0;
         dec_w       <= '0;
         bin_sr      <= '0;
         frac_w      <= '0;
         bcd_sr      <= '0;
         fb_sr       <= '0;
         entero      <= '0;
         decimal     <= '0;
         entero_bcd  <= '0;
         decimal_bcd <= '0;
         negativo    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (estado)
            IDLE: if (in_valid) begin
               neg_w  <= neg_in;
               ovf_w  <= fuera;
               ent_w  <= ent_in;
               dec_w  <= dec_in;
               bin_sr <= ent_in;
               frac_w <= dec_in;
               bcd_sr <= '0;
               fb_sr  <= '0;
               cnt    <= '0;
            end
            INT_CONV: begin
               {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
               cnt              <= ult_int ? '0 : cnt + CNT_W'(1);
            end
            FRAC_CONV: begin
               fb_sr  <= fb_next;
               frac_w <= t[FRAC_W-1:0];
               cnt    <= cnt + CNT_W'(1);
               // Results become visible only as DONE is entered, including the last digit.
               if (ult_frac) begin
                  entero      <= ent_w;
                  decimal     <= dec_w;
                  entero_bcd  <= bcd_sr;
                  decimal_bcd <= fb_next;
                  negativo    <= neg_w;
                  overflow    <= ovf_w;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adaptador_fijo_bcd.sv
// Bench for adaptador_fijo_bcd: unsigned and signed instances, vector table, random
// samples against an arithmetic model, backpressure and mid-conversion reset.
module tb_adaptador_fijo_bcd;

   typedef struct packed {
      logic [15:0] ent;
      logic [3:0]  dec;
      logic [19:0] ebcd;
      logic [7:0]  dbcd;
      logic        neg;
      logic        ovf;
   } res_t;

   typedef struct {
      bit          sgn;
      logic [23:0] v;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] fp = '0;
   logic        iv_u = 1'b0, iv_s = 1'b0;
   logic        out_ready = 1'b1;

   logic        rdy_u, rdy_s, vld_u, vld_s, neg_u, neg_s, ovf_u, ovf_s;
   logic [15:0] ent_u, ent_s;
   logic [3:0]  dec_u, dec_s;
   logic [19:0] ebcd_u, ebcd_s;
   logic [7:0]  dbcd_u, dbcd_s;
   logic [1:0]  st_u, st_s;
   res_t        got_u, got_s;

   res_t exp_q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   adaptador_fijo_bcd u_uns (
      .clk(clk), .reset(reset), .fixedPoint(fp), .in_valid(iv_u), .in_ready(rdy_u),
      .entero(ent_u), .decimal(dec_u), .entero_bcd(ebcd_u), .decimal_bcd(dbcd_u),
      .negativo(neg_u), .overflow(ovf_u), .out_valid(vld_u), .out_ready(out_ready),
      .estado_dbg(st_u)
   );

   adaptador_fijo_bcd #(.SIGNED(1'b1)) u_sgn (
      .clk(clk), .reset(reset), .fixedPoint(fp), .in_valid(iv_s), .in_ready(rdy_s),
      .entero(ent_s), .decimal(dec_s), .entero_bcd(ebcd_s), .decimal_bcd(dbcd_s),
      .negativo(neg_s), .overflow(ovf_s), .out_valid(vld_s), .out_ready(out_ready),
      .estado_dbg(st_s)
   );

   assign got_u = {ent_u, dec_u, ebcd_u, dbcd_u, neg_u, ovf_u};
   assign got_s = {ent_s, dec_s, ebcd_s, dbcd_s, neg_s, ovf_s};

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%h exp=%h", name, act, exp);
   endtask

   task automatic chk_res(input string tag, input res_t g, input res_t e);
      chk({tag, "_entero"},      32'(g.ent),  32'(e.ent));
      chk({tag, "_decimal"},     32'(g.dec),  32'(e.dec));
      chk({tag, "_entero_bcd"},  32'(g.ebcd), 32'(e.ebcd));
      chk({tag, "_decimal_bcd"}, 32'(g.dbcd), 32'(e.dbcd));
      chk({tag, "_negativo"},    32'(g.neg),  32'(e.neg));
      chk({tag, "_overflow"},    32'(g.ovf),  32'(e.ovf));
   endtask

   // Reference: plain integer arithmetic on the sample's numeric value.
   function automatic res_t model(input bit sgn, input logic [23:0] v);
      longint val, mag, ent, frac, div;
      res_t   r;
      val = sgn ? longint'($signed(v)) : longint'({40'd0, v});
      mag = (val < 0) ? -val : val;
      r.neg = (val < 0);
      if (mag >= (longint'(1) << 20)) begin
         r.ovf = 1'b1; ent = 65535; frac = 15;
      end else begin
         r.ovf = 1'b0; ent = mag / 16; frac = mag % 16;
      end
      r.ent = 16'(ent);
      r.dec = 4'(frac);
      div = 1;
      for (int d = 0; d < 5; d++) begin
         r.ebcd[4*d +: 4] = 4'((ent / div) % 10);
         div = div * 10;
      end
      r.dbcd[7:4] = 4'(((frac * 10) / 16) % 10);
      r.dbcd[3:0] = 4'(((frac * 100) / 16) % 10);
      return r;
   endfunction

   task automatic send(input bit sgn, input logic [23:0] v);
      int n = 0;
      while (!(sgn ? rdy_s : rdy_u) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready_before_send", 32'(sgn ? rdy_s : rdy_u), 32'd1);
      fp = v;
      if (sgn) iv_s = 1'b1; else iv_u = 1'b1;
      @(posedge clk); #1;
      iv_s = 1'b0; iv_u = 1'b0;
   endtask

   task automatic wait_done(input bit sgn, output int n);
      n = 0;
      while (!(sgn ? vld_s : vld_u) && n < 200) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic run_one(input bit sgn, input logic [23:0] v, input res_t e, input string tag);
      int   lat;
      res_t x;
      send(sgn, v);
      exp_q.push_back(e);
      wait_done(sgn, lat);
      chk({tag, "_latency"}, 32'(lat), 32'd18);
      x = exp_q.pop_front();
      chk_res(tag, sgn ? got_s : got_u, x);
      @(posedge clk); #1;
      chk({tag, "_out_valid_fall"}, 32'(sgn ? vld_s : vld_u), 32'd0);
      chk({tag, "_in_ready_rise"},  32'(sgn ? rdy_s : rdy_u), 32'd1);
   endtask

   vec_t tbl[9];
   res_t r_7b8, r_10, r_zero;

   initial begin
      r_7b8  = '{ent: 16'd123,   dec: 4'h8, ebcd: 20'h00123, dbcd: 8'h50, neg: 1'b0, ovf: 1'b0};
      r_10   = '{ent: 16'd1,     dec: 4'h0, ebcd: 20'h00001, dbcd: 8'h00, neg: 1'b0, ovf: 1'b0};
      r_zero = '0;
      tbl[0] = '{1'b0, 24'h0007B8, r_7b8};
      tbl[1] = '{1'b0, 24'h100000, '{16'hFFFF, 4'hF, 20'h65535, 8'h93, 1'b0, 1'b1}};
      tbl[2] = '{1'b1, 24'hFFFFF8, '{16'h0000, 4'h8, 20'h00000, 8'h50, 1'b1, 1'b0}};
      tbl[3] = '{1'b1, 24'h800000, '{16'hFFFF, 4'hF, 20'h65535, 8'h93, 1'b1, 1'b1}};
      tbl[4] = '{1'b0, 24'h000000, r_zero};
      tbl[5] = '{1'b0, 24'h0FFFFF, '{16'hFFFF, 4'hF, 20'h65535, 8'h93, 1'b0, 1'b0}};
      tbl[6] = '{1'b1, 24'h0FFFFF, '{16'hFFFF, 4'hF, 20'h65535, 8'h93, 1'b0, 1'b0}};
      tbl[7] = '{1'b1, 24'hF00001, '{16'hFFFF, 4'hF, 20'h65535, 8'h93, 1'b1, 1'b0}};
      tbl[8] = '{1'b0, 24'h000010, r_10};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_res("reset_u", got_u, r_zero);
      chk("reset_in_ready", 32'(rdy_u), 32'd1);
      chk("reset_out_valid", 32'(vld_u), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_one(tbl[i].sgn, tbl[i].v, tbl[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         bit          s;
         logic [23:0] v;
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) v = 24'($urandom_range(0, 24'hFFFFFF));
         else v = 24'($urandom_range(0, 24'h0FFFFF)) | (s && $urandom_range(0, 1) == 1 ? 24'hF00000 : 24'h0);
         run_one(s, v, model(s, v), $sformatf("rnd%0d", i));
      end

      // Backpressure: result held for 5 cycles, stray in_valid ignored
      out_ready = 1'b0;
      begin
         int lat;
         send(1'b0, 24'h0007B8);
         wait_done(1'b0, lat);
         chk("bp_latency", 32'(lat), 32'd18);
         for (int c = 0; c < 5; c++) begin
            if (c == 2) begin fp = 24'h000320; iv_u = 1'b1; end
            @(posedge clk); #1;
            iv_u = 1'b0;
            chk_res($sformatf("bp_hold%0d", c), got_u, r_7b8);
            chk($sformatf("bp_in_ready%0d", c), 32'(rdy_u), 32'd0);
            chk($sformatf("bp_out_valid%0d", c), 32'(vld_u), 32'd1);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         chk("bp_release_out_valid", 32'(vld_u), 32'd0);
         chk("bp_release_in_ready", 32'(rdy_u), 32'd1);
         run_one(1'b0, 24'h000010, r_10, "bp_next");
      end

      // Reset during INT_CONV
      run_one(1'b0, 24'h100000, model(1'b0, 24'h100000), "pre_reset");
      send(1'b0, 24'h0007B8);
      repeat (6) @(posedge clk);
      #1;
      chk("mid_state_int_conv", 32'(st_u), 32'd1);
      reset = 1'b1;
      #1;
      chk_res("mid_reset", got_u, r_zero);
      chk("mid_reset_in_ready", 32'(rdy_u), 32'd1);
      chk("mid_reset_out_valid", 32'(vld_u), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      run_one(1'b0, 24'h000010, r_10, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
